// File: rtl/alu_decode_stage.sv
// alu_decode_stage
// ----------------
// Decode / operand-fetch stage feeding the integer ALU. Accepts RV32I
// instructions of the OP, OP-IMM and LUI groups over a valid/ready handshake,
// reads rs1/rs2 from an internal 32x32 register file (with same-cycle
// writeback bypass) and presents a registered ALU command.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   instruction handshake (in_ready is combinational)
//   in_instr            RV32I instruction word
//   wb_en/addr/data     register file write port
//   flush               drop the held command and any instruction offered now
//   out_valid/out_ready ALU command handshake
//   out_sel             ALU op (ADD=0 SUB=1 SLT=2 SLTU=3 AND=4 OR=5 XOR=6
//                       SLL=7 SRL=8 SRA=9)
//   out_shift_amt       {1'b0, 5-bit shift amount}
//   out_data_a/b        ALU operands
//   out_rd/out_rd_we    destination register and write enable
//   out_illegal         instruction outside the supported set
module alu_decode_stage #(
  parameter int XLEN       = 32,
  parameter int SEL_SIZE   = 5,
  parameter int SHIFT_SIZE = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic                  wb_en,
  input  logic [4:0]            wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_SIZE-1:0]   out_sel,
  output logic [SHIFT_SIZE:0]   out_shift_amt,
  output logic [XLEN-1:0]       out_data_a,
  output logic [XLEN-1:0]       out_data_b,
  output logic [4:0]            out_rd,
  output logic                  out_rd_we,
  output logic                  out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [SEL_SIZE-1:0] SEL_ADD  = SEL_SIZE'(0);
  localparam logic [SEL_SIZE-1:0] SEL_SUB  = SEL_SIZE'(1);
  localparam logic [SEL_SIZE-1:0] SEL_SLT  = SEL_SIZE'(2);
  localparam logic [SEL_SIZE-1:0] SEL_SLTU = SEL_SIZE'(3);
  localparam logic [SEL_SIZE-1:0] SEL_AND  = SEL_SIZE'(4);
  localparam logic [SEL_SIZE-1:0] SEL_OR   = SEL_SIZE'(5);
  localparam logic [SEL_SIZE-1:0] SEL_XOR  = SEL_SIZE'(6);
  localparam logic [SEL_SIZE-1:0] SEL_SLL  = SEL_SIZE'(7);
  localparam logic [SEL_SIZE-1:0] SEL_SRL  = SEL_SIZE'(8);
  localparam logic [SEL_SIZE-1:0] SEL_SRA  = SEL_SIZE'(9);

  // Register read with x0 hardwired to zero and writeback forwarding, so an
  // instruction accepted in the same cycle as its producer's writeback sees
  // the new value.
  function automatic logic [XLEN-1:0] bypass_read(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] stored,
    input logic            we,
    input logic [4:0]      waddr,
    input logic [XLEN-1:0] wdata
  );
    logic [XLEN-1:0] val;
    if (addr == 5'd0) begin
      val = {XLEN{1'b0}};
    end else if (we && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  logic [XLEN-1:0] regs [0:31];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;

  logic [XLEN-1:0]       rs1_val;
  logic [XLEN-1:0]       rs2_val;
  logic [XLEN-1:0]       imm_i;
  logic [XLEN-1:0]       imm_u;
  logic [SHIFT_SIZE:0]   shamt_reg;
  logic [SHIFT_SIZE:0]   shamt_imm;

  logic [SEL_SIZE-1:0]   dec_sel;
  logic [SHIFT_SIZE:0]   dec_shamt;
  logic [XLEN-1:0]       dec_a;
  logic [XLEN-1:0]       dec_b;
  logic                  dec_legal;
  logic                  accept;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  assign rs1_val   = bypass_read(rs1, regs[rs1], wb_en, wb_addr, wb_data);
  assign rs2_val   = bypass_read(rs2, regs[rs2], wb_en, wb_addr, wb_data);
  assign imm_i     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_u     = XLEN'({in_instr[31:12], 12'h000});
  assign shamt_reg = {1'b0, rs2_val[SHIFT_SIZE-1:0]};
  assign shamt_imm = {1'b0, in_instr[20+SHIFT_SIZE-1:20]};

  // A new command can be taken whenever the output slot is empty or drains now.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Register file: synchronous clear, writes to x0 discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= {XLEN{1'b0}};
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Instruction decode and operand selection.
  always_comb begin
    dec_sel   = SEL_ADD;
    dec_shamt = {(SHIFT_SIZE+1){1'b0}};
    dec_a     = {XLEN{1'b0}};
    dec_b     = {XLEN{1'b0}};
    dec_legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_legal = (funct7 == F7_ZERO);
        dec_a     = rs1_val;
        dec_b     = rs2_val;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_ALT) begin
              // The ALU computes b - a, so SUB presents rs2 on a and rs1 on b.
              dec_legal = 1'b1;
              dec_sel   = SEL_SUB;
              dec_a     = rs2_val;
              dec_b     = rs1_val;
            end else begin
              dec_sel = SEL_ADD;
            end
          end
          3'b001: begin
            dec_sel   = SEL_SLL;
            dec_shamt = shamt_reg;
          end
          3'b010: dec_sel = SEL_SLT;
          3'b011: dec_sel = SEL_SLTU;
          3'b100: dec_sel = SEL_XOR;
          3'b101: begin
            dec_shamt = shamt_reg;
            if (funct7 == F7_ALT) begin
              dec_legal = 1'b1;
              dec_sel   = SEL_SRA;
            end else begin
              dec_sel = SEL_SRL;
            end
          end
          3'b110: dec_sel = SEL_OR;
          3'b111: dec_sel = SEL_AND;
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec_legal = 1'b1;
        dec_a     = rs1_val;
        dec_b     = imm_i;
        case (funct3)
          3'b000: dec_sel = SEL_ADD;
          3'b001: begin
            dec_sel   = SEL_SLL;
            dec_shamt = shamt_imm;
            dec_legal = (funct7 == F7_ZERO);
          end
          3'b010: dec_sel = SEL_SLT;
          3'b011: dec_sel = SEL_SLTU;
          3'b100: dec_sel = SEL_XOR;
          3'b101: begin
            dec_shamt = shamt_imm;
            if (funct7 == F7_ALT) begin
              dec_sel = SEL_SRA;
            end else begin
              dec_sel   = SEL_SRL;
              dec_legal = (funct7 == F7_ZERO);
            end
          end
          3'b110: dec_sel = SEL_OR;
          3'b111: dec_sel = SEL_AND;
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_sel   = SEL_ADD;
        dec_a     = {XLEN{1'b0}};
        dec_b     = imm_u;
      end
      default: dec_legal = 1'b0;
    endcase
    // Illegal instructions present a neutral command with no writeback.
    if (!dec_legal) begin
      dec_sel   = SEL_ADD;
      dec_shamt = {(SHIFT_SIZE+1){1'b0}};
      dec_a     = {XLEN{1'b0}};
      dec_b     = {XLEN{1'b0}};
    end else begin
      dec_sel   = dec_sel;
    end
  end

  // Output command register: reset > flush > accept > drain > hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_sel       <= {SEL_SIZE{1'b0}};
      out_shift_amt <= {(SHIFT_SIZE+1){1'b0}};
      out_data_a    <= {XLEN{1'b0}};
      out_data_b    <= {XLEN{1'b0}};
      out_rd        <= 5'd0;
      out_rd_we     <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_sel       <= dec_sel;
      out_shift_amt <= dec_shamt;
      out_data_a    <= dec_a;
      out_data_b    <= dec_b;
      out_rd        <= rd;
      out_rd_we     <= dec_legal && (rd != 5'd0);
      out_illegal   <= !dec_legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Testbench for alu_decode_stage: directed scenarios plus randomized traffic.
// A driver computes expected commands from a behavioural model and queues
// them; a monitor pops and compares whenever the DUT hands a command over.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_sel;
  logic [5:0]  out_shift_amt;
  logic [31:0] out_data_a;
  logic [31:0] out_data_b;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_shift_amt(out_shift_amt),
    .out_data_a(out_data_a), .out_data_b(out_data_b), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  sel;
    logic [5:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_regs [32];
  int          op_of_f3 [8] = '{0, 7, 2, 3, 6, 8, 5, 4};
  bit          m_valid = 1'b0;
  bit          cur_valid = 1'b0;
  bit          exp_ready = 1'b1;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] rv(input logic [4:0] r, input logic we, input logic [4:0] wa,
                                     input logic [31:0] wd);
    if (r == 5'd0) return 32'h0;
    if (we && wa == r) return wd;
    return model_regs[r];
  endfunction

  // Behavioural reference: name the operation first, then build its operands.
  function automatic exp_t ref_cmd(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                                   input logic [31:0] wd);
    exp_t e;
    int op;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [31:0] v1, v2, imm;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    v1 = rv(ins[19:15], we, wa, wd);
    v2 = rv(ins[24:20], we, wa, wd);
    imm = {{20{ins[31]}}, ins[31:20]};
    op = -1;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) op = op_of_f3[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
      else if (f7 == 7'h20 && f3 == 3'd5) op = 9;
    end else if (opc == 7'h13) begin
      if (f3 != 3'd1 && f3 != 3'd5) op = op_of_f3[f3];
      else if (f7 == 7'h00) op = op_of_f3[f3];
      else if (f3 == 3'd5 && f7 == 7'h20) op = 9;
    end else if (opc == 7'h37) begin
      op = 10;
    end
    e = '0;
    e.rd = ins[11:7];
    if (op < 0) begin
      e.ill = 1'b1;
    end else if (op == 10) begin
      e.b = ins & 32'hFFFFF000;
      e.we = (e.rd != 5'd0);
    end else begin
      e.sel = 5'(op);
      e.we = (e.rd != 5'd0);
      e.a = v1;
      e.b = (opc == 7'h33) ? v2 : imm;
      if (op == 1) begin
        e.a = v2;
        e.b = v1;
      end
      if (op >= 7) e.sh = (opc == 7'h33) ? {1'b0, v2[4:0]} : {1'b0, ins[24:20]};
    end
    return e;
  endfunction

  // Drive one cycle of inputs and advance the model to match.
  task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic ordy,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic rstn);
    bit acc;
    @(posedge clk); #1;
    rst_n = rstn; in_valid = v; in_instr = ins; flush = fl; out_ready = ordy;
    wb_en = we; wb_addr = wa; wb_data = wd;
    if (!rstn) begin
      exp_q.delete();
      m_valid = 1'b0;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    end else begin
      cur_valid = m_valid;
      exp_ready = !m_valid || ordy;
      acc = v && exp_ready && !fl;
      if (fl && m_valid && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_cmd(ins, we, wa, wd));
      if (fl) m_valid = 1'b0;
      else if (acc) m_valid = 1'b1;
      else if (ordy) m_valid = 1'b0;
      if (we && wa != 5'd0) model_regs[wa] = wd;
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 1'b0, ordy, 1'b0, 5'd0, 32'h0, 1'b1);
  endtask

  task automatic issue(input logic [31:0] ins, input logic ordy);
    step(1'b1, ins, 1'b0, ordy, 1'b0, 5'd0, 32'h0, 1'b1);
  endtask

  task automatic wb(input logic [4:0] wa, input logic [31:0] wd);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, wa, wd, 1'b1);
  endtask

  // Monitor: handshake state every cycle, command contents on each hand-over.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("out_valid", {31'h0, out_valid}, {31'h0, cur_valid});
      chk("in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("sel", {27'h0, out_sel}, {27'h0, e.sel});
          chk("shift_amt", {26'h0, out_shift_amt}, {26'h0, e.sh});
          chk("data_a", out_data_a, e.a);
          chk("data_b", out_data_b, e.b);
          chk("rd", {27'h0, out_rd}, {27'h0, e.rd});
          chk("rd_we", {31'h0, out_rd_we}, {31'h0, e.we});
          chk("illegal", {31'h0, out_illegal}, {31'h0, e.ill});
        end
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  f7;
    int          kind;

    // Reset state
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    idle(1'b1); #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_fields", {out_sel, out_shift_amt, out_rd, out_rd_we, out_illegal}, 32'h0);
    chk("rst_a", out_data_a, 32'h0);
    chk("rst_b", out_data_b, 32'h0);
    issue(32'h005282B3, 1'b1);
    idle(1'b1); #1;
    chk("add_x5_a", out_data_a, 32'h0);
    chk("add_x5_b", out_data_b, 32'h0);

    // SUB operand swap
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd3);
    issue(32'h402081B3, 1'b1);
    idle(1'b1); #1;
    chk("sub_sel", {27'h0, out_sel}, 32'd1);
    chk("sub_a", out_data_a, 32'd3);
    chk("sub_b", out_data_b, 32'd5);
    chk("sub_rd", {27'h0, out_rd}, 32'd3);
    chk("sub_we", {31'h0, out_rd_we}, 32'h1);

    // Same-cycle writeback bypass
    step(1'b1, 32'hFFF08213, 1'b0, 1'b1, 1'b1, 5'd1, 32'hDEADBEEF, 1'b1);
    idle(1'b1); #1;
    chk("byp_sel", {27'h0, out_sel}, 32'd0);
    chk("byp_a", out_data_a, 32'hDEADBEEF);
    chk("byp_b", out_data_b, 32'hFFFFFFFF);
    chk("byp_rd", {27'h0, out_rd}, 32'd4);

    // Backpressure with writeback to the source register
    wb(5'd6, 32'h12345678);
    issue(32'h41F35293, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h02131293, 1'b0, 1'b0, (k == 0), 5'd6, 32'hFFFF0000, 1'b1); #1;
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_valid", {31'h0, out_valid}, 32'h1);
      chk("srai_sel", {27'h0, out_sel}, 32'd9);
      chk("srai_sh", {26'h0, out_shift_amt}, 32'd31);
      chk("srai_a", out_data_a, 32'h12345678);
      chk("srai_b", out_data_b, 32'h0000041F);
    end
    issue(32'h02131293, 1'b1); #1;
    chk("bp_release_ready", {31'h0, in_ready}, 32'h1);
    idle(1'b1); #1;
    chk("ill_flag", {31'h0, out_illegal}, 32'h1);
    chk("ill_we", {31'h0, out_rd_we}, 32'h0);
    chk("ill_a", out_data_a, 32'h0);
    chk("ill_b", out_data_b, 32'h0);
    chk("ill_sel", {27'h0, out_sel}, 32'h0);

    // Flush drops held command and offered instruction
    issue(32'h402081B3, 1'b1);
    step(1'b1, 32'hFFF08213, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    idle(1'b1); #1;
    chk("flush_valid", {31'h0, out_valid}, 32'h0);
    idle(1'b1); #1;
    chk("flush_dropped", {31'h0, out_valid}, 32'h0);

    // Writes to x0 are ignored
    wb(5'd0, 32'd7);
    issue(32'h000000B3, 1'b1);
    idle(1'b1); #1;
    chk("x0_a", out_data_a, 32'h0);
    chk("x0_b", out_data_b, 32'h0);
    chk("x0_rd", {27'h0, out_rd}, 32'd1);

    // Reset while a command is held also clears the register file
    issue(32'h402081B3, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    idle(1'b1); #1;
    chk("midrst_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_a", out_data_a, 32'h0);
    issue(32'hFFF08213, 1'b1);
    idle(1'b1); #1;
    chk("midrst_x1_cleared", out_data_a, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: f7 = 7'h00;
        6, 7: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      ins = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
             5'($urandom_range(0, 7)), 7'h33};
      if (kind >= 4 && kind <= 7) ins[6:0] = 7'h13;
      else if (kind == 8) ins[6:0] = 7'h37;
      else if (kind == 9) ins = $urandom;
      step(($urandom_range(0, 3) != 0), ins, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 299) != 0));
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Decode/operand-fetch stage that sits directly upstream of the ALU.
- Accepts 32-bit RV32I instructions over a valid/ready handshake and reads rs1/rs2 from an internal 32x32 register file, which has a writeback port with same-cycle bypass.
- Produces a registered ALU command: sel, shift_amt, operand A, operand B and destination.
- Covers the integer register-register (OP), register-immediate (OP-IMM) and LUI instruction groups.

Parameters:
- XLEN, 32, data/register width.
- SEL_SIZE, 5, width of the ALU operation select.
- SHIFT_SIZE, 5, shift_amt output is SHIFT_SIZE+1 bits wide.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_instr is valid.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_instr  input  32  RV32I instruction word.
- wb_en  input  1  register file write enable.
- wb_addr  input  5  register file write address.
- wb_data  input  XLEN  register file write data.
- flush  input  1  discard the held output and any instruction offered this cycle.
- out_valid  output  1  ALU command valid.
- out_ready  input  1  downstream ALU stage accepts the command.
- out_sel  output  SEL_SIZE  ALU op: ADD=0 SUB=1 SLT=2 SLTU=3 AND=4 OR=5 XOR=6 SLL=7 SRL=8 SRA=9.
- out_shift_amt  output  SHIFT_SIZE+1  shift amount, {1'b0, 5-bit amount}.
- out_data_a  output  XLEN  ALU data_in_a.
- out_data_b  output  XLEN  ALU data_in_b.
- out_rd  output  5  destination register.
- out_rd_we  output  1  result is to be written back.
- out_illegal  output  1  instruction not in the supported set.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset: rst_n=0 at a clock edge clears out_valid and every out_* field to 0 and clears all 32 registers to 0. Reset mid-transfer drops the held command.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - An accept (in_valid & in_ready & !flush) loads the output register next edge; latency is 1 cycle.
  - While out_valid & !out_ready, all out_* fields hold stable.
  - out_valid clears when the held command is consumed and nothing new is accepted.
- Flush: flush=1 clears out_valid next edge and blocks any accept that cycle. flush has priority over accept; rst_n has priority over flush.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - Write occurs at the edge when wb_en=1.
  - Read bypass: if wb_en & wb_addr==rs & rs!=0 in the accept cycle, wb_data is used as the operand.
  - Writeback during a stall does not alter held outputs.
- Decode for OP (0110011), by funct7/funct3:
  - 0000000/000 ADD, 0100000/000 SUB
  - 0000000/001 SLL, 0000000/010 SLT, 0000000/011 SLTU, 0000000/100 XOR
  - 0000000/101 SRL, 0100000/101 SRA
  - 0000000/110 OR, 0000000/111 AND
  - any other combination is illegal.
- Decode for OP-IMM (0010011):
  - funct3 000/010/011/100/110/111 map to ADD/SLT/SLTU/XOR/OR/AND.
  - 001 with instr[31:25]=0000000 is SLL.
  - 101 with instr[31:25]=0000000 is SRL; with 0100000 it is SRA.
  - any other combination is illegal.
- LUI (0110111): sel=ADD, a=0, b={instr[31:12],12'b0}. Any other opcode is illegal.
- Operand mapping:
  - Default: a=rs1 value; b=rs2 value (OP) or sign-extended instr[31:20] (OP-IMM).
  - SUB swaps operands, a=rs2 value and b=rs1 value, because the ALU computes b-a.
  - Shifts: shift_amt = {1'b0, rs2 value[4:0]} for OP or {1'b0, instr[24:20]} for OP-IMM. shift_amt=0 for non-shift ops.
- Destination: out_rd=instr[11:7]; out_rd_we=1 iff legal and rd!=0.
- Illegal instruction: out_illegal=1, sel=0, a=b=0, shift_amt=0, rd_we=0, out_valid=1. Presents like any other command.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then release -> out_valid=0, in_ready=1, all out_* 0. ADD x5,x5,x5 afterwards gives a=b=0.
- Register SUB: writeback x1=5 and x2=3, then issue 0x402081B3 (sub x3,x1,x2) -> next cycle out_sel=1, a=3, b=5, rd=3, rd_we=1.
- Bypass: wb_en x1=0xDEADBEEF in the same cycle that 0xFFF08213 (addi x4,x1,-1) is accepted -> sel=0, a=0xDEADBEEF, b=0xFFFFFFFF, rd=4.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and outputs stable; writeback to the source register meanwhile leaves a unchanged; out_ready=1 then accepts the next instruction.
- Shifts and illegal: 0x41F35293 (srai x5,x6,31) -> sel=9, shift_amt=31. 0x02131293 (slli with funct7=0000001) -> out_illegal=1, rd_we=0, a=b=0.
- Flush and x0: flush=1 with in_valid=1 and out_valid=1 -> out_valid=0 next cycle and the instruction is dropped. Writeback x0=7, then add x1,x0,x0 -> a=b=0.
